// File: rtl/decode_queue_pkg.sv
// Shared RV32I decode constants, instruction-type codes and the decoded-entry
// record passed from the field decoder into the decode queue.
package decode_queue_pkg;

  localparam logic [6:0] OPCODE_U_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_U_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_J_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_I_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_B_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_I_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_S_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_I_IMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_R_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_I_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_I_CSR    = 7'b1110011;

  // funct3/funct7 values used by the legality checks
  localparam logic [2:0] F3_ADD_SUB   = 3'b000;
  localparam logic [2:0] F3_SLL       = 3'b001;
  localparam logic [2:0] F3_SR        = 3'b101;
  localparam logic [2:0] F3_JALR      = 3'b000;
  localparam logic [2:0] F3_STORE_MAX = 3'b010;
  localparam logic [6:0] F7_BASE      = 7'h00;
  localparam logic [6:0] F7_ALT       = 7'h20;

  typedef enum logic [3:0] {
    TYPE_R       = 4'd0,
    TYPE_I       = 4'd1,
    TYPE_S       = 4'd2,
    TYPE_B       = 4'd3,
    TYPE_U       = 4'd4,
    TYPE_J       = 4'd5,
    TYPE_INVALID = 4'hF
  } instr_type_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    instr_type_e typ;
    logic [31:0] imm;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch-side and execute-side handshake bundle of the decode queue.
interface decode_queue_if
  import decode_queue_pkg::*;
#(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_funct7;
  instr_type_e     out_type;
  logic [31:0]     out_imm;
  logic [PC_W-1:0] out_pc;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_funct3, out_rs1,
           out_rs2, out_funct7, out_type, out_imm, out_pc, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_funct3, out_rs1,
           out_rs2, out_funct7, out_type, out_imm, out_pc, out_illegal
  );
endinterface

// File: rtl/decode_fields.sv
// Combinational RV32I field decoder: instruction word -> fields, type,
// sign-extended immediate and illegal-instruction flag.
module decode_fields
  import decode_queue_pkg::*;
#(
  parameter bit EN_ZICSR = 1'b1,
  parameter bit EN_FENCE = 1'b1
) (
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  instr_type_e typ;
  logic [31:0] imm;
  logic        ill;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // NOTE: every variable gets a default before the case statements so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    typ = TYPE_INVALID;
    imm = '0;
    ill = 1'b0;

    case (opcode)
      OPCODE_U_LUI, OPCODE_U_AUIPC:                 typ = TYPE_U;
      OPCODE_J_JAL:                                 typ = TYPE_J;
      OPCODE_I_JALR, OPCODE_I_LOAD, OPCODE_I_IMM,
      OPCODE_I_FENCE, OPCODE_I_CSR:                 typ = TYPE_I;
      OPCODE_B_BRANCH:                              typ = TYPE_B;
      OPCODE_S_STORE:                               typ = TYPE_S;
      OPCODE_R_OP:                                  typ = TYPE_R;
      default:                                      typ = TYPE_INVALID;
    endcase

    case (typ)
      TYPE_I:  imm = {{20{instr[31]}}, instr[31:20]};
      TYPE_S:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      TYPE_B:  imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      TYPE_U:  imm = {instr[31:12], 12'b0};
      TYPE_J:  imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase

    ill = (instr[1:0] != 2'b11) || (typ == TYPE_INVALID);
    case (opcode)
      OPCODE_I_CSR:    if (!EN_ZICSR) ill = 1'b1;
      OPCODE_I_FENCE:  if (!EN_FENCE) ill = 1'b1;
      OPCODE_B_BRANCH: if (funct3 inside {3'd2, 3'd3}) ill = 1'b1;
      OPCODE_I_LOAD:   if (funct3 inside {3'd3, 3'd6, 3'd7}) ill = 1'b1;
      OPCODE_S_STORE:  if (funct3 > F3_STORE_MAX) ill = 1'b1;
      OPCODE_I_JALR:   if (funct3 != F3_JALR) ill = 1'b1;
      OPCODE_R_OP: begin
        // Only SUB and SRA use the alternate funct7
        if (!((funct7 == F7_BASE) ||
              ((funct7 == F7_ALT) && (funct3 inside {F3_ADD_SUB, F3_SR}))))
          ill = 1'b1;
      end
      OPCODE_I_IMM: begin
        if ((funct3 == F3_SLL) && (funct7 != F7_BASE))
          ill = 1'b1;
        else if ((funct3 == F3_SR) && !(funct7 inside {F7_BASE, F7_ALT}))
          ill = 1'b1;
      end
      default: ;
    endcase
  end

  assign dec = '{opcode:  opcode,
                 rd:      instr[11:7],
                 funct3:  funct3,
                 rs1:     instr[19:15],
                 rs2:     instr[24:20],
                 funct7:  funct7,
                 typ:     typ,
                 imm:     imm,
                 illegal: ill};

endmodule

// File: rtl/decode_queue.sv
// Registered RV32I decode stage: decodes on the fetch side and buffers
// decoded entries in a DEPTH-entry circular FIFO toward execute.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int PC_W     = 32,
  parameter bit EN_ZICSR = 1'b1,
  parameter bit EN_FENCE = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  decode_queue_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    decoded_t        dec;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  entry_t             last_q;
  decoded_t           in_dec;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push, pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  decode_fields #(
    .EN_ZICSR (EN_ZICSR),
    .EN_FENCE (EN_FENCE)
  ) u_fields (
    .instr (bus.in_instr),
    .dec   (in_dec)
  );

  assign bus.out_valid = (count != '0);
  // A full queue still accepts when its head leaves in the same cycle
  assign bus.in_ready  = (count < CNT_W'(DEPTH)) || bus.out_ready;
  assign push          = bus.in_valid && bus.in_ready && !flush;
  assign pop           = bus.out_valid && bus.out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array carries no reset; a slot is only read after it
  // has been written, and reset-time outputs come from last_q instead.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{dec: in_dec, pc: bus.in_pc};
  end

  // Keeps the outputs steady once the queue drains or is flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             last_q <= '0;
    else if (bus.out_valid) last_q <= mem[rd_ptr];
  end

  assign head = bus.out_valid ? mem[rd_ptr] : last_q;

  assign bus.out_opcode  = head.dec.opcode;
  assign bus.out_rd      = head.dec.rd;
  assign bus.out_funct3  = head.dec.funct3;
  assign bus.out_rs1     = head.dec.rs1;
  assign bus.out_rs2     = head.dec.rs2;
  assign bus.out_funct7  = head.dec.funct7;
  assign bus.out_type    = head.dec.typ;
  assign bus.out_imm     = head.dec.imm;
  assign bus.out_pc      = head.pc;
  assign bus.out_illegal = head.dec.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: vector table streamed through a
// scoreboard, plus backpressure, full-throughput, flush and reset sequences.
module tb_decode_queue;
  import decode_queue_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    instr_type_e typ;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pop = 0;
  logic [31:0] next_pc = 32'h0000_1000;
  exp_t cur;
  exp_t mon_e;
  exp_t sb [$];
  exp_t vecs [16];

  decode_queue_if #(.PC_W(32)) dq ();

  decode_queue #(
    .DEPTH    (2),
    .PC_W     (32),
    .EN_ZICSR (1'b1),
    .EN_FENCE (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (dq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_exp(input exp_t e);
    return 128'({e.instr[6:0], e.instr[11:7], e.instr[14:12], e.instr[19:15],
                 e.instr[24:20], e.instr[31:25], 4'(e.typ), e.imm, e.pc, e.ill});
  endfunction

  function automatic logic [127:0] pack_act();
    return 128'({dq.out_opcode, dq.out_rd, dq.out_funct3, dq.out_rs1, dq.out_rs2,
                 dq.out_funct7, 4'(dq.out_type), dq.out_imm, dq.out_pc, dq.out_illegal});
  endfunction

  // Scoreboard: inputs and out_ready are stable at the falling edge, so the
  // handshakes that will fire on the next rising edge are decided here.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (dq.out_valid && dq.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pop", 128'(1), 128'(0));
        end else begin
          mon_e = sb.pop_front();
          check("head_entry", pack_act(), pack_exp(mon_e));
          n_pop++;
        end
      end
      if (flush) sb.delete();
      else if (dq.in_valid && dq.in_ready) sb.push_back(cur);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input exp_t v);
    cur          = v;
    cur.pc       = next_pc;
    dq.in_valid  = 1'b1;
    dq.in_instr  = v.instr;
    dq.in_pc     = next_pc;
    next_pc      = next_pc + 32'd4;
  endtask

  task automatic drain(input string name);
    dq.in_valid  = 1'b0;
    dq.out_ready = 1'b1;
    for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
    step();
    check({name, "_drained"}, 128'(sb.size()), 128'(0));
    check({name, "_idle_valid"}, 128'(dq.out_valid), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, pops %0d", n_pop);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h00500093, 0, TYPE_I,       32'h0000_0005, 1'b0}; // addi x1,x0,5
    vecs[1]  = '{32'h12345137, 0, TYPE_U,       32'h1234_5000, 1'b0}; // lui x2
    vecs[2]  = '{32'hFE000EE3, 0, TYPE_B,       32'hFFFF_FFFC, 1'b0}; // beq -4
    vecs[3]  = '{32'h00000000, 0, TYPE_INVALID, 32'h0000_0000, 1'b1}; // all zero
    vecs[4]  = '{32'h0000700F, 0, TYPE_I,       32'h0000_0000, 1'b1}; // fence, disabled
    vecs[5]  = '{32'h40001033, 0, TYPE_R,       32'h0000_0000, 1'b1}; // sll with funct7 0x20
    vecs[6]  = '{32'h00512423, 0, TYPE_S,       32'h0000_0008, 1'b0}; // sw x5,8(x2)
    vecs[7]  = '{32'hFF9FF0EF, 0, TYPE_J,       32'hFFFF_FFF8, 1'b0}; // jal x1,-8
    vecs[8]  = '{32'hFFF22183, 0, TYPE_I,       32'hFFFF_FFFF, 1'b0}; // lw x3,-1(x4)
    vecs[9]  = '{32'h00023183, 0, TYPE_I,       32'h0000_0000, 1'b1}; // load funct3 3
    vecs[10] = '{32'h4030D093, 0, TYPE_I,       32'h0000_0403, 1'b0}; // srai x1,x1,3
    vecs[11] = '{32'h40309093, 0, TYPE_I,       32'h0000_0403, 1'b1}; // slli with funct7 0x20
    vecs[12] = '{32'h300110F3, 0, TYPE_I,       32'h0000_0300, 1'b0}; // csrrw, enabled
    vecs[13] = '{32'h402081B3, 0, TYPE_R,       32'h0000_0000, 1'b0}; // sub x3,x1,x2
    vecs[14] = '{32'hFFFFF297, 0, TYPE_U,       32'hFFFF_F000, 1'b0}; // auipc x5
    vecs[15] = '{32'h00009067, 0, TYPE_I,       32'h0000_0000, 1'b1}; // jalr funct3 1

    rst_n        = 1'b0;
    flush        = 1'b0;
    dq.in_valid  = 1'b0;
    dq.in_instr  = '0;
    dq.in_pc     = '0;
    dq.out_ready = 1'b0;
    cur          = vecs[0];

    // Reset state
    #1;
    check("rst_out_valid", 128'(dq.out_valid), 128'(0));
    check("rst_out_data", pack_act(), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 128'(dq.in_ready), 128'(1));

    // Single-cycle latency, no bypass
    dq.out_ready = 1'b1;
    apply(vecs[0]);
    @(negedge clk);
    check("no_bypass", 128'(dq.out_valid), 128'(0));
    step();
    dq.in_valid = 1'b0;
    check("latency_1", 128'(dq.out_valid), 128'(1));
    drain("latency");

    // Vector table streamed back to back
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
      step();
    end
    drain("table");

    // Backpressure: two fill the queue, the third waits for out_ready
    dq.out_ready = 1'b0;
    apply(vecs[6]);  step();
    apply(vecs[7]);  step();
    apply(vecs[8]);
    @(negedge clk);
    check("full_in_ready", 128'(dq.in_ready), 128'(0));
    step();
    #2;
    check("full_hold_ready", 128'(dq.in_ready), 128'(0));
    dq.out_ready = 1'b1;
    #1;
    check("ready_on_pop", 128'(dq.in_ready), 128'(1));
    step();
    drain("backpressure");

    // Full queue with push and pop every cycle
    dq.out_ready = 1'b0;
    apply(vecs[0]);  step();
    apply(vecs[1]);  step();
    dq.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply(vecs[2 + i]);
      @(negedge clk);
      check("stream_in_ready", 128'(dq.in_ready), 128'(1));
      check("stream_out_valid", 128'(dq.out_valid), 128'(1));
      step();
    end
    dq.in_valid  = 1'b0;
    dq.out_ready = 1'b0;
    #1;
    check("stream_still_full", 128'(dq.in_ready), 128'(0));
    drain("stream");

    // Flush with two queued entries and a pending push
    dq.out_ready = 1'b0;
    apply(vecs[12]); step();
    apply(vecs[13]); step();
    apply(vecs[14]);
    flush = 1'b1;
    step();
    flush       = 1'b0;
    dq.in_valid = 1'b0;
    check("flush_full_valid", 128'(dq.out_valid), 128'(0));

    // Flush with one queued entry while the push would otherwise be accepted
    apply(vecs[10]); step();
    apply(vecs[11]);
    flush = 1'b1;
    #1;
    check("flush_push_ready", 128'(dq.in_ready), 128'(1));
    step();
    flush       = 1'b0;
    dq.in_valid = 1'b0;
    check("flush_one_valid", 128'(dq.out_valid), 128'(0));
    step();
    check("flush_push_dropped", 128'(dq.out_valid), 128'(0));
    drain("flush");

    // Asynchronous reset mid-stream
    dq.out_ready = 1'b0;
    apply(vecs[1]);
    step();
    dq.in_valid = 1'b0;
    #2;
    check("pre_reset_valid", 128'(dq.out_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 128'(dq.out_valid), 128'(0));
    check("async_rst_imm", 128'(dq.out_imm), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 128'(dq.in_ready), 128'(1));
    check("post_rst_valid", 128'(dq.out_valid), 128'(0));

    check("total_pops", 128'(n_pop), 128'(1 + 16 + 3 + 10));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
